// File: rtl/pe_mac_stream.sv
// Systolic-array processing element: forwards operands east/south and multiply-accumulates
// valid operand pairs, with optional signed arithmetic, saturation and a shift-chain readout.
module pe_mac_stream #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int SIGNED = 0,
  parameter int SAT    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] u,
  input  logic              u_vld,
  input  logic [DATA_W-1:0] l,
  input  logic              l_vld,
  input  logic              clr,
  input  logic              load,
  input  logic              shift,
  input  logic [ACC_W-1:0]  sin,
  input  logic              sin_vld,
  output logic [DATA_W-1:0] r,
  output logic              r_vld,
  output logic [DATA_W-1:0] d,
  output logic              d_vld,
  output logic [ACC_W-1:0]  out,
  output logic              out_vld,
  output logic              ovf
);

  localparam int PROD_W = 2 * DATA_W;

  logic [DATA_W-1:0] r_fwd_l, r_fwd_u;
  logic              r_fwd_l_vld, r_fwd_u_vld;
  logic [ACC_W-1:0]  r_acc, r_out;
  logic              r_out_vld, r_ovf;

  logic              w_mac;
  logic [PROD_W-1:0] w_prod;
  logic [ACC_W-1:0]  w_prod_ext, w_addend, w_lhs, w_raw, w_sat, w_res;
  logic [ACC_W:0]    w_wide;
  logic              w_ovf;

  assign w_mac = u_vld & l_vld;

  // Operands are extended to the full product width before multiplying; the low PROD_W
  // bits of that product are identical for signed and unsigned interpretation.
  assign w_prod = (SIGNED != 0) ? (PROD_W'($signed(u)) * PROD_W'($signed(l)))
                                : (PROD_W'(u) * PROD_W'(l));
  assign w_prod_ext = (SIGNED != 0) ? ACC_W'($signed(w_prod)) : ACC_W'(w_prod);
  assign w_addend   = w_mac ? w_prod_ext : '0;

  // load ignores clr so the final sum always includes the accumulated value.
  assign w_lhs  = (clr & ~load) ? '0 : r_acc;
  assign w_wide = {1'b0, w_lhs} + {1'b0, w_addend};
  assign w_raw  = w_wide[ACC_W-1:0];

  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    w_ovf = 1'b0;
    w_sat = '1;
    if (SIGNED != 0) begin
      w_ovf = (w_lhs[ACC_W-1] == w_addend[ACC_W-1]) && (w_raw[ACC_W-1] != w_lhs[ACC_W-1]);
      w_sat = w_lhs[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      w_ovf = w_wide[ACC_W];
    end
  end

  assign w_res = ((SAT != 0) && w_ovf) ? w_sat : w_raw;

  // NOTE: non-blocking assignments keep every register update race-free within the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fwd_l     <= '0;
      r_fwd_u     <= '0;
      r_fwd_l_vld <= 1'b0;
      r_fwd_u_vld <= 1'b0;
      r_acc       <= '0;
      r_out       <= '0;
      r_out_vld   <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_fwd_l     <= l;
      r_fwd_u     <= u;
      r_fwd_l_vld <= l_vld;
      r_fwd_u_vld <= u_vld;
      if (load) begin
        r_acc     <= '0;
        r_out     <= w_res;
        r_out_vld <= 1'b1;
      end else begin
        r_acc <= w_res;
        if (shift) begin
          r_out     <= sin;
          r_out_vld <= sin_vld;
        end else begin
          r_out_vld <= 1'b0;
        end
      end
      // Sticky flag; a clr/load cycle restarts it from that cycle's own overflow.
      r_ovf <= (clr | load) ? w_ovf : (r_ovf | w_ovf);
    end
  end

  assign r       = r_fwd_l;
  assign r_vld   = r_fwd_l_vld;
  assign d       = r_fwd_u;
  assign d_vld   = r_fwd_u_vld;
  assign out     = r_out;
  assign out_vld = r_out_vld;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_pe_mac_stream.sv
// Directed bench for pe_mac_stream: default, 16-bit saturating/wrapping and signed
// instances share one stimulus stream; a separate 3-PE column exercises the shift chain.
module tb_pe_mac_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, u_vld, l_vld, clr, load;
  logic [7:0] u, l;

  // Default instance
  logic [7:0]  a_r, a_d;
  logic        a_r_vld, a_d_vld, a_out_vld, a_ovf;
  logic [23:0] a_out;
  // ACC_W=16, SAT=1
  logic [7:0]  s_r, s_d;
  logic        s_r_vld, s_d_vld, s_out_vld, s_ovf;
  logic [15:0] s_out;
  // ACC_W=16, SAT=0
  logic [7:0]  w_r, w_d;
  logic        w_r_vld, w_d_vld, w_out_vld, w_ovf;
  logic [15:0] w_out;
  // SIGNED=1
  logic [7:0]  g_r, g_d;
  logic        g_r_vld, g_d_vld, g_out_vld, g_ovf;
  logic [23:0] g_out;

  pe_mac_stream u_a (
    .clk(clk), .rst(rst), .u(u), .u_vld(u_vld), .l(l), .l_vld(l_vld), .clr(clr), .load(load),
    .shift(1'b0), .sin(24'd0), .sin_vld(1'b0), .r(a_r), .r_vld(a_r_vld), .d(a_d), .d_vld(a_d_vld),
    .out(a_out), .out_vld(a_out_vld), .ovf(a_ovf));

  pe_mac_stream #(.ACC_W(16), .SAT(1)) u_s (
    .clk(clk), .rst(rst), .u(u), .u_vld(u_vld), .l(l), .l_vld(l_vld), .clr(clr), .load(load),
    .shift(1'b0), .sin(16'd0), .sin_vld(1'b0), .r(s_r), .r_vld(s_r_vld), .d(s_d), .d_vld(s_d_vld),
    .out(s_out), .out_vld(s_out_vld), .ovf(s_ovf));

  pe_mac_stream #(.ACC_W(16), .SAT(0)) u_w (
    .clk(clk), .rst(rst), .u(u), .u_vld(u_vld), .l(l), .l_vld(l_vld), .clr(clr), .load(load),
    .shift(1'b0), .sin(16'd0), .sin_vld(1'b0), .r(w_r), .r_vld(w_r_vld), .d(w_d), .d_vld(w_d_vld),
    .out(w_out), .out_vld(w_out_vld), .ovf(w_ovf));

  pe_mac_stream #(.SIGNED(1)) u_g (
    .clk(clk), .rst(rst), .u(u), .u_vld(u_vld), .l(l), .l_vld(l_vld), .clr(clr), .load(load),
    .shift(1'b0), .sin(24'd0), .sin_vld(1'b0), .r(g_r), .r_vld(g_r_vld), .d(g_d), .d_vld(g_d_vld),
    .out(g_out), .out_vld(g_out_vld), .ovf(g_ovf));

  // Three-PE column: out of each PE feeds sin of the next one down.
  logic [7:0]  cu0, cu1, cu2;
  logic        c_vld, c_load, c_shift, c_sin_vld;
  logic [7:0]  c0_r, c0_d, c1_r, c1_d, c2_r, c2_d;
  logic        c0_r_vld, c0_d_vld, c1_r_vld, c1_d_vld, c2_r_vld, c2_d_vld;
  logic [23:0] c0_out, c1_out, c2_out;
  logic        c0_out_vld, c1_out_vld, c2_out_vld, c0_ovf, c1_ovf, c2_ovf;

  pe_mac_stream u_c0 (
    .clk(clk), .rst(rst), .u(cu0), .u_vld(c_vld), .l(8'd1), .l_vld(c_vld), .clr(1'b0),
    .load(c_load), .shift(c_shift), .sin(24'd0), .sin_vld(c_sin_vld), .r(c0_r), .r_vld(c0_r_vld),
    .d(c0_d), .d_vld(c0_d_vld), .out(c0_out), .out_vld(c0_out_vld), .ovf(c0_ovf));

  pe_mac_stream u_c1 (
    .clk(clk), .rst(rst), .u(cu1), .u_vld(c_vld), .l(8'd1), .l_vld(c_vld), .clr(1'b0),
    .load(c_load), .shift(c_shift), .sin(c0_out), .sin_vld(c0_out_vld), .r(c1_r), .r_vld(c1_r_vld),
    .d(c1_d), .d_vld(c1_d_vld), .out(c1_out), .out_vld(c1_out_vld), .ovf(c1_ovf));

  pe_mac_stream u_c2 (
    .clk(clk), .rst(rst), .u(cu2), .u_vld(c_vld), .l(8'd1), .l_vld(c_vld), .clr(1'b0),
    .load(c_load), .shift(c_shift), .sin(c1_out), .sin_vld(c1_out_vld), .r(c2_r), .r_vld(c2_r_vld),
    .d(c2_d), .d_vld(c2_d_vld), .out(c2_out), .out_vld(c2_out_vld), .ovf(c2_ovf));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; u = '0; l = '0; u_vld = 1'b0; l_vld = 1'b0; clr = 1'b0; load = 1'b0;
    cu0 = '0; cu1 = '0; cu2 = '0; c_vld = 1'b0; c_load = 1'b0; c_shift = 1'b0; c_sin_vld = 1'b0;
    tick(); tick();
    chk("rst_out", a_out, 0);
    chk("rst_out_vld", a_out_vld, 0);
    chk("rst_r", a_r, 0);
    chk("rst_d_vld", a_d_vld, 0);
    chk("rst_ovf", a_ovf, 0);
    rst = 1'b0;

    // T1 forwarding
    u = 8'd7; l = 8'd5; u_vld = 1'b1; l_vld = 1'b1; tick();
    chk("fwd_d", a_d, 7);
    chk("fwd_r", a_r, 5);
    chk("fwd_d_vld", a_d_vld, 1);
    chk("fwd_r_vld", a_r_vld, 1);
    u_vld = 1'b0; l_vld = 1'b0; tick();
    chk("fwd_d_vld_low", a_d_vld, 0);
    chk("fwd_r_vld_low", a_r_vld, 0);
    chk("fwd_d_data_kept", a_d, 7);

    // T2 accumulate and load: 3*2 + 12*7 + 1*1 = 91
    rst = 1'b1; tick(); rst = 1'b0;
    u = 8'd3; l = 8'd2; u_vld = 1'b1; l_vld = 1'b1; tick();
    u = 8'd12; l = 8'd7; tick();
    u = 8'd1; l = 8'd1; load = 1'b1; tick();
    chk("load_out", a_out, 91);
    chk("load_out_vld", a_out_vld, 1);
    load = 1'b0; u_vld = 1'b0; l_vld = 1'b0; tick();
    chk("idle_out_vld", a_out_vld, 0);
    chk("idle_out_hold", a_out, 91);
    load = 1'b1; tick();
    chk("load_acc_cleared", a_out, 0);
    load = 1'b0;

    // T3 clr with MAC, then single-valid operand
    u = 8'd5; l = 8'd10; u_vld = 1'b1; l_vld = 1'b1; tick();
    clr = 1'b1; u = 8'd4; l = 8'd5; tick();
    clr = 1'b0; u = 8'd9; l = 8'd9; l_vld = 1'b0; tick();
    u_vld = 1'b0; load = 1'b1; tick();
    chk("clr_mac_acc", a_out, 20);
    load = 1'b0;

    // T4 saturation vs wrap at ACC_W=16: 2*65025 = 130050
    rst = 1'b1; tick(); rst = 1'b0;
    u = 8'd255; l = 8'd255; u_vld = 1'b1; l_vld = 1'b1; tick();
    chk("sat_ovf_first", s_ovf, 0);
    chk("wrap_ovf_first", w_ovf, 0);
    tick();
    chk("sat_ovf", s_ovf, 1);
    chk("wrap_ovf", w_ovf, 1);
    u_vld = 1'b0; l_vld = 1'b0; load = 1'b1; tick();
    chk("sat_out", s_out, 65535);
    chk("wrap_out", w_out, 64514);
    chk("sat_ovf_load_clears", s_ovf, 0);
    load = 1'b0; u_vld = 1'b1; l_vld = 1'b1; tick(); tick();
    u_vld = 1'b0; l_vld = 1'b0; tick();
    chk("wrap_ovf_sticky", w_ovf, 1);
    clr = 1'b1; tick();
    chk("wrap_ovf_clr", w_ovf, 0);
    clr = 1'b0; load = 1'b1; tick();
    chk("wrap_clr_acc", w_out, 0);
    load = 1'b0;

    // T5 signed: -3*5 = -15, then -15 + (-3*-3) = -6
    rst = 1'b1; tick(); rst = 1'b0;
    u = 8'hFD; l = 8'd5; u_vld = 1'b1; l_vld = 1'b1; tick();
    u_vld = 1'b0; l_vld = 1'b0; load = 1'b1; tick();
    chk("signed_out", g_out, 24'hFFFFF1);
    chk("signed_out_vld", g_out_vld, 1);
    load = 1'b0; u_vld = 1'b1; l_vld = 1'b1; tick();
    u = 8'hFD; l = 8'hFD; load = 1'b1; tick();
    chk("signed_neg_neg", g_out, 24'hFFFFFA);
    chk("signed_ovf", g_ovf, 0);
    load = 1'b0; u_vld = 1'b0; l_vld = 1'b0;

    // T6 chain: load 10/20/30 then shift the column toward the tail
    rst = 1'b1; tick(); rst = 1'b0;
    cu0 = 8'd10; cu1 = 8'd20; cu2 = 8'd30; c_vld = 1'b1; c_load = 1'b1; tick();
    chk("chain_head_load", c0_out, 10);
    chk("chain_tail_load", c2_out, 30);
    chk("chain_tail_vld0", c2_out_vld, 1);
    c_vld = 1'b0; c_load = 1'b0; c_shift = 1'b1; c_sin_vld = 1'b1; tick();
    chk("chain_shift1", c2_out, 20);
    chk("chain_shift1_vld", c2_out_vld, 1);
    tick();
    chk("chain_shift2", c2_out, 10);
    chk("chain_shift2_vld", c2_out_vld, 1);
    tick();
    chk("chain_shift3", c2_out, 0);
    chk("chain_shift3_vld", c2_out_vld, 1);
    c_shift = 1'b0; c_sin_vld = 1'b0; tick();
    chk("chain_idle_vld", c2_out_vld, 0);

    // Reset mid-accumulation discards the accumulator
    u = 8'd3; l = 8'd3; u_vld = 1'b1; l_vld = 1'b1; tick();
    rst = 1'b1; load = 1'b1; tick();
    chk("rstmid_out", a_out, 0);
    chk("rstmid_out_vld", a_out_vld, 0);
    chk("rstmid_d", a_d, 0);
    chk("rstmid_r_vld", a_r_vld, 0);
    rst = 1'b0; u_vld = 1'b0; l_vld = 1'b0; tick();
    chk("rstmid_acc_gone", a_out, 0);
    chk("rstmid_load_vld", a_out_vld, 1);
    load = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
